// File: rtl/fifo_push_arbiter.sv
// Purpose : round-robin arbiter sharing one fifo_flops push port among n_req req/ack producers, credit-tracked.
// Latency : grant decided in cycle N; ack, fifo_push, fifo_din and grant_id are all registered and appear in N+1.
// Backpr. : no grant while fifo_full=1 or no credit is left after the in-flight push; requesters hold req/data and wait.
//
// Ports:
//   clk, rst (async, active-low)
//   req[n_req], data_in[n_req*width]  : producer side; requester i data at [i*width +: width]
//   ack[n_req]                        : one-cycle one-hot acknowledge, aligned with fifo_push
//   fifo_full, fifo_pndng, fifo_pop   : fifo_flops status; fifo_pop is only observed
//   fifo_push, fifo_din               : registered push port into fifo_flops
//   grant_id, credits, underflow_err  : served index, tracked free slots, sticky over-pop flag
//   stat_sel, stat_cnt                : only with FIFO_ARB_STATS_EN (per-requester grant counters)
module fifo_push_arbiter #(
    parameter int width = 16,
    parameter int depth = 8,
    parameter int n_req = 4,
    localparam int sel_w  = $clog2(n_req),
    localparam int cred_w = $clog2(depth + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n_req-1:0]         req,
    input  logic [n_req*width-1:0]   data_in,
    output logic [n_req-1:0]         ack,
    input  logic                     fifo_full,
    input  logic                     fifo_pndng,
    input  logic                     fifo_pop,
    output logic                     fifo_push,
    output logic [width-1:0]         fifo_din,
    output logic [sel_w-1:0]         grant_id,
    output logic [cred_w-1:0]        credits,
    output logic                     underflow_err
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic [sel_w-1:0]         stat_sel,
    output logic [15:0]              stat_cnt
`endif
);

    localparam logic [cred_w-1:0] cred_max = cred_w'(depth);

    logic [sel_w-1:0] last;
    logic [n_req-1:0] req_elig;
    logic             win_vld;
    logic [sel_w-1:0] win_idx;
    logic             cred_ok;
    logic             grant;
    logic             pop_v;

    // A requester whose ack is high this cycle still shows its old req;
    // masking it keeps the same word from being granted twice.
    assign req_elig = req & ~ack;

    // The push currently on the port has not been subtracted from credits
    // yet, so it must be accounted for before promising another slot.
    assign cred_ok = credits > cred_w'(fifo_push);
    assign grant   = win_vld & cred_ok & ~fifo_full;
    assign pop_v   = fifo_pop & fifo_pndng;

    // Cyclic search starting just after the last winner.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= n_req; k++) begin
            idx = (int'(last) + k) % n_req;
            if (!win_vld && req_elig[idx]) begin
                win_vld = 1'b1;
                win_idx = sel_w'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack       <= '0;
            fifo_push <= 1'b0;
            fifo_din  <= '0;
            grant_id  <= '0;
            last      <= sel_w'(n_req - 1);
        end else begin
            fifo_push <= grant;
            ack       <= grant ? ({{(n_req-1){1'b0}}, 1'b1} << win_idx) : '0;
            if (grant) begin
                fifo_din <= data_in[int'(win_idx)*width +: width];
                grant_id <= win_idx;
                last     <= win_idx;
            end
        end
    end

    // Push and valid pop in the same cycle cancel out. The range guards
    // keep the counter inside [0, depth] even if the FIFO side misbehaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits       <= cred_max;
            underflow_err <= 1'b0;
        end else begin
            if (fifo_push && !pop_v) begin
                if (credits != '0) begin
                    credits <= credits - cred_w'(1);
                end
            end else if (!fifo_push && pop_v) begin
                if (credits != cred_max) begin
                    credits <= credits + cred_w'(1);
                end
            end
            // A pop while every slot is believed free means the FIFO and the
            // arbiter disagree; latch it for software to inspect.
            if (pop_v && (credits == cred_max)) begin
                underflow_err <= 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] grant_cnt [n_req];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < n_req; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < n_req; i++) begin
                if (ack[i] && (grant_cnt[i] != 16'hFFFF)) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign stat_cnt = (int'(stat_sel) < n_req) ? grant_cnt[stat_sel] : 16'd0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Purpose : self-checking bench for fifo_push_arbiter (width 16, depth 8, 4 requesters).
// Latency : outputs compared every cycle on the falling edge against a reference model.
// Backpr. : producers hold req/data until acked; FIFO occupancy modelled to drive pndng.
module tb_fifo_push_arbiter;

    localparam int W = 16;
    localparam int D = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   ack;
    logic           fifo_full;
    logic           fifo_pndng;
    logic           fifo_pop;
    logic           fifo_push;
    logic [W-1:0]   fifo_din;
    logic [1:0]     grant_id;
    logic [3:0]     credits;
    logic           underflow_err;
`ifdef FIFO_ARB_STATS_EN
    logic [1:0]     stat_sel;
    logic [15:0]    stat_cnt;
`endif

    fifo_push_arbiter #(.width(W), .depth(D), .n_req(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .data_in       (data_in),
        .ack           (ack),
        .fifo_full     (fifo_full),
        .fifo_pndng    (fifo_pndng),
        .fifo_pop      (fifo_pop),
        .fifo_push     (fifo_push),
        .fifo_din      (fifo_din),
        .grant_id      (grant_id),
        .credits       (credits),
        .underflow_err (underflow_err)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_sel      (stat_sel),
        .stat_cnt      (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the outputs must be in the current cycle.
    logic [N-1:0] m_ack;
    bit           m_push;
    logic [W-1:0] m_din;
    int           m_gid;
    int           m_cred;
    bit           m_err;
    int           m_last;
    int           m_stat [N];
    int           occ;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ack  = '0;
        m_push = 0;
        m_din  = '0;
        m_gid  = 0;
        m_cred = D;
        m_err  = 0;
        m_last = N - 1;
        occ    = 0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
    endtask

    // Inputs must already be set; advances one clock and checks every output.
    task automatic step();
        bit           g;
        int           w;
        bit           popv;
        int           n_cred;
        logic [W-1:0] wdat;
        popv = fifo_pop && fifo_pndng;
        g    = 0;
        w    = 0;
        if ((m_cred - int'(m_push)) > 0 && !fifo_full) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (!g && req[idx] && !m_ack[idx]) begin
                    g = 1;
                    w = idx;
                end
            end
        end
        wdat   = data_in[w*W +: W];
        n_cred = m_cred - int'(m_push) + int'(popv);
        if (n_cred > D) n_cred = D;
        if (n_cred < 0) n_cred = 0;
        if (popv && m_cred == D) m_err = 1;
        for (int i = 0; i < N; i++)
            if (m_ack[i] && m_stat[i] < 65535) m_stat[i]++;
        occ = occ + int'(m_push) - int'(popv);
        if (occ < 0) occ = 0;
        @(posedge clk);
        m_cred = n_cred;
        m_push = g;
        m_ack  = g ? N'(1 << w) : '0;
        if (g) begin
            m_din  = wdat;
            m_gid  = w;
            m_last = w;
        end
        @(negedge clk);
        chk("ack",       32'(ack),           32'(m_ack));
        chk("fifo_push", 32'(fifo_push),     32'(m_push));
        chk("fifo_din",  32'(fifo_din),      32'(m_din));
        chk("grant_id",  32'(grant_id),      32'(m_gid));
        chk("credits",   32'(credits),       32'(m_cred));
        chk("underflow", 32'(underflow_err), 32'(m_err));
`ifdef FIFO_ARB_STATS_EN
        chk("stat_cnt",  32'(stat_cnt),      32'(m_stat[stat_sel]));
`endif
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_ack",   32'(ack),           32'd0);
        chk("rst_push",  32'(fifo_push),     32'd0);
        chk("rst_din",   32'(fifo_din),      32'd0);
        chk("rst_gid",   32'(grant_id),      32'd0);
        chk("rst_cred",  32'(credits),       32'd8);
        chk("rst_err",   32'(underflow_err), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        rst        = 1'b1;
        req        = '0;
        data_in    = '0;
        fifo_full  = 1'b0;
        fifo_pndng = 1'b0;
        fifo_pop   = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_sel   = 2'd2;
`endif
        model_reset();
        #2;
        do_reset();

        // Single requester from reset.
        data_in[15:0] = 16'h00A5;
        req = 4'b0001;
        step();
        chk("t1_ack",  32'(ack),       32'h1);
        chk("t1_push", 32'(fifo_push), 32'd1);
        chk("t1_din",  32'(fifo_din),  32'h00A5);
        chk("t1_gid",  32'(grant_id),  32'd0);
        req = 4'b0000;
        step();
        chk("t1_cred", 32'(credits),   32'd7);

        // All four requesting: rotation then stall at zero credits.
        do_reset();
        data_in = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_gid",  32'(grant_id),  32'(k % 4));
            chk("t2_push", 32'(fifo_push), 32'd1);
        end
        step();
        chk("t2_cred",  32'(credits),   32'd0);
        chk("t2_push0", 32'(fifo_push), 32'd0);
        step();
        chk("t2_ack0",  32'(ack),       32'd0);

        // One valid pop frees one slot; requester 0 is next.
        fifo_pop = 1'b1; fifo_pndng = 1'b1;
        step();
        chk("t3_cred1", 32'(credits),   32'd1);
        fifo_pop = 1'b0; fifo_pndng = 1'b0;
        step();
        chk("t3_push",  32'(fifo_push), 32'd1);
        chk("t3_gid",   32'(grant_id),  32'd0);
        step();
        chk("t3_cred0", 32'(credits),   32'd0);

        // Push and valid pop together; pop without pndng ignored.
        do_reset();
        req = 4'b1111;
        repeat (6) step();
        chk("t4_cred3a", 32'(credits),   32'd3);
        chk("t4_push",   32'(fifo_push), 32'd1);
        fifo_pop = 1'b1; fifo_pndng = 1'b1;
        step();
        chk("t4_cred3b", 32'(credits),   32'd3);
        fifo_pop = 1'b1; fifo_pndng = 1'b0;
        step();
        chk("t4_cred2",  32'(credits),   32'd2);
        fifo_pop = 1'b0;

        // Pop while the FIFO is believed empty.
        do_reset();
        req = 4'b0000;
        fifo_pop = 1'b1; fifo_pndng = 1'b1;
        step();
        chk("t5_cred", 32'(credits),       32'd8);
        chk("t5_err",  32'(underflow_err), 32'd1);
        fifo_pop = 1'b0; fifo_pndng = 1'b0;
        step();
        chk("t5_sticky", 32'(underflow_err), 32'd1);

        // Reset in the middle of a burst.
        do_reset();
        req = 4'b1111;
        repeat (3) step();
        chk("t6_pre_push", 32'(fifo_push), 32'd1);
        do_reset();
        step();
        chk("t6_push", 32'(fifo_push), 32'd1);
        chk("t6_gid",  32'(grant_id),  32'd0);

`ifdef FIFO_ARB_STATS_EN
        // Five grants to requester 2, read back through stat_sel.
        do_reset();
        stat_sel = 2'd2;
        req = 4'b0100;
        seen = 0;
        for (int c = 0; c < 30 && seen < 5; c++) begin
            step();
            if (ack[2]) seen++;
        end
        chk("stat_grants_seen", 32'(seen), 32'd5);
        req = 4'b0000;
        step();
        chk("stat_cnt_r2", 32'(stat_cnt), 32'd5);
`endif

        // Randomized traffic with a FIFO occupancy model and occasional resets.
        do_reset();
        req = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_ack[i]) begin
                        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                        else data_in[i*W +: W] = 16'($urandom);
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    data_in[i*W +: W] = 16'($urandom);
                end
            end
            fifo_pndng = (occ > 0);
            if (((cyc / 500) % 2) == 0) fifo_pop = ($urandom_range(0, 3) == 0);
            else fifo_pop = ($urandom_range(0, 3) != 0);
            fifo_full = ($urandom_range(0, 9) == 0);
`ifdef FIFO_ARB_STATS_EN
            stat_sel = 2'($urandom_range(0, 3));
`endif
            if ((cyc % 1000) == 999) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
